// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers DATA_W-bit samples from a frame-based PWM stream.
// Frame length is 2**DATA_W clocks; high time in a frame is sample+1 clocks.
// Optional build macro PWM_DEC_AVG_EN: output is the rounded mean of the
// previous and current decoded frames (first frame after lock is passed raw).
//
// state | meaning
// ------+---------------------------------------------------------------
// HUNT  | not aligned; counters parked at 0, waiting for a rising edge
// TRACK | aligned; counting frame position and high cycles, emitting samples
module pwm_decoder #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              pwm_in,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   output logic              locked,
   output logic              sync_err
);

   typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

   localparam logic [DATA_W-1:0] FCNT_MAX = '1;
   localparam logic [DATA_W-1:0] FCNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W:0]   HCNT_ONE = {{DATA_W{1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    s, s_d, rise;
   logic [DATA_W-1:0]       fcnt_q, fcnt_d;
   logic [DATA_W:0]         hcnt_q, hcnt_d;
   logic [DATA_W:0]         final_cnt;
   logic [DATA_W-1:0]       raw;
   logic [DATA_W-1:0]       out_d;
   logic                    load, err_d;

   assign s      = sync_q[SYNC_STAGES-1];
   assign rise   = s & ~s_d;
   assign locked = (state_q == TRACK);

   // Synchronizer chain plus one delay flop for edge detection.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_d    <= s;
      end
   end

   // State and frame counters.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= HUNT;
         fcnt_q  <= '0;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         hcnt_q  <= hcnt_d;
      end
   end

   // Next-state: a rise anywhere but frame position 0 restarts the frame there;
   // an all-low frame means the stream is gone.
   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      hcnt_d    = hcnt_q;
      load      = 1'b0;
      err_d     = 1'b0;
      final_cnt = hcnt_q + {{DATA_W{1'b0}}, s};
      // final_cnt of 2**DATA_W wraps to the all-ones sample here.
      raw       = final_cnt[DATA_W-1:0] - FCNT_ONE;
      case (state_q)
         HUNT: begin
            fcnt_d = '0;
            hcnt_d = '0;
            if (rise) begin
               state_d = TRACK;
               fcnt_d  = FCNT_ONE;
               hcnt_d  = HCNT_ONE;
            end
         end
         TRACK: begin
            if (rise && (fcnt_q != '0)) begin
               err_d  = 1'b1;
               fcnt_d = FCNT_ONE;
               hcnt_d = HCNT_ONE;
            end else if (fcnt_q == FCNT_MAX) begin
               fcnt_d = '0;
               hcnt_d = '0;
               if (final_cnt == '0) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  load = 1'b1;
               end
            end else begin
               fcnt_d = fcnt_q + FCNT_ONE;
               hcnt_d = final_cnt;
            end
         end
         default: state_d = HUNT;
      endcase
   end

`ifdef PWM_DEC_AVG_EN
   logic [DATA_W-1:0] prev_raw_q;
   logic              have_prev_q;
   logic [DATA_W:0]   avg_sum;

   // Rounded mean: (a+b+1)>>1 == ((a+b)>>1) + lsb(a+b), never overflows DATA_W.
   always_comb begin
      avg_sum = {1'b0, prev_raw_q} + {1'b0, raw};
      out_d   = raw;
      if (have_prev_q) out_d = avg_sum[DATA_W:1] + {{(DATA_W-1){1'b0}}, avg_sum[0]};
   end

   // Previous raw sample; forgotten whenever alignment is lost.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_raw_q  <= '0;
         have_prev_q <= 1'b0;
      end else if (state_q == HUNT) begin
         prev_raw_q  <= '0;
         have_prev_q <= 1'b0;
      end else if (load) begin
         prev_raw_q  <= raw;
         have_prev_q <= 1'b1;
      end
   end
`else
   assign out_d = raw;
`endif

   // Registered outputs; sample_out holds between valid pulses.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sample_out   <= '0;
         sample_valid <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         sample_valid <= load;
         sync_err     <= err_d;
         if (load) sample_out <= out_d;
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: encoder-style frames driven directly, a window-sum
// reference model checked every cycle, plus literal checkpoints.
`timescale 1ns/1ps
module tb_pwm_decoder;

   localparam int DATA_W = 8;
   localparam int SYNC   = 2;
   localparam int FRAME  = 256;

   logic              clk    = 1'b0;
   logic              n_rst  = 1'b0;
   logic              pwm_in = 1'b0;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic              locked;
   logic              sync_err;

   int checks   = 0;
   int failures = 0;

   pwm_decoder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .pwm_in       (pwm_in),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .locked       (locked),
      .sync_err     (sync_err)
   );

   always #50 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: s is pwm_in delayed by the synchronizer; a frame is the
   // 256 samples after the alignment anchor, its value is (ones in window)-1.
   bit pin_hist[$];
   bit s_hist[$];
   bit m_s_prev, m_locked, m_have_prev;
   int m_anchor, m_t, m_prev;
   int exp_sample;
   bit exp_valid, exp_err;

   task automatic model_step();
      bit s, rise;
      int pos, sum, raw;
      s    = pin_hist[0];
      rise = s && !m_s_prev;
      s_hist.push_back(s);
      if (s_hist.size() > FRAME) void'(s_hist.pop_front());
      exp_valid = 0;
      exp_err   = 0;
      pos = (m_t - m_anchor) % FRAME;
      if (!m_locked) begin
         if (rise) begin
            m_locked = 1;
            m_anchor = m_t;
         end
      end else if (rise && pos != 0) begin
         exp_err  = 1;
         m_anchor = m_t;
      end else if (pos == FRAME - 1) begin
         sum = 0;
         foreach (s_hist[i]) sum += int'(s_hist[i]);
         if (sum == 0) begin
            exp_err     = 1;
            m_locked    = 0;
            m_have_prev = 0;
         end else begin
            raw = sum - 1;
`ifdef PWM_DEC_AVG_EN
            exp_sample = m_have_prev ? (m_prev + raw + 1) / 2 : raw;
`else
            exp_sample = raw;
`endif
            m_prev      = raw;
            m_have_prev = 1;
            exp_valid   = 1;
         end
      end
      m_s_prev = s;
      m_t++;
      pin_hist.push_back(pwm_in);
      void'(pin_hist.pop_front());
   endtask

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pin_hist.delete();
         for (int i = 0; i < SYNC; i++) pin_hist.push_back(1'b0);
         s_hist.delete();
         m_s_prev = 0; m_locked = 0; m_have_prev = 0;
         m_anchor = 0; m_t = 0; m_prev = 0;
         exp_sample = 0; exp_valid = 0; exp_err = 0;
      end else begin
         model_step();
      end
   end

   // Per-cycle comparison against the model, plus DUT event counters.
   int n_valid = 0;
   int n_err   = 0;
   int last_s  = 0;
   int vq[$];

   always @(negedge clk) begin
      chk("sample_out",   int'(sample_out),   exp_sample);
      chk("sample_valid", int'(sample_valid), int'(exp_valid));
      chk("locked",       int'(locked),       int'(m_locked));
      chk("sync_err",     int'(sync_err),     int'(exp_err));
      if (sample_valid) begin
         n_valid++;
         last_s = int'(sample_out);
         vq.push_back(int'(sample_out));
      end
      if (sync_err) n_err++;
   end

   task automatic tick(input bit v);
      @(negedge clk);
      pwm_in = v;
   endtask

   task automatic frame(input int smp, input int len = FRAME);
      for (int i = 0; i < len; i++) tick(i <= smp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_sample_out", int'(sample_out), 0);
      chk("rst_valid",      int'(sample_valid), 0);
      chk("rst_locked",     int'(locked), 0);
      chk("rst_err",        int'(sync_err), 0);
      @(negedge clk);
      n_rst = 1'b1;

      frame(100);
      chk("lock_after_f1", int'(locked), 1);
      chk("nvalid_f1", n_valid, 0);
      repeat (3) frame(100);
      frame(0);
      chk("nvalid_100", n_valid, 4);
      chk("last_100", last_s, 100);
      chk("model_last_100", exp_sample, 100);
      chk("nerr_100", n_err, 0);

      frame(0);
      frame(255);
      chk("nvalid_0", n_valid, 6);
      chk("last_0", last_s, 0);

      frame(255);
      frame(255);
      frame(50);
      chk("nvalid_255", n_valid, 9);
      chk("last_255", last_s, 255);
      chk("model_last_255", exp_sample, 255);
      chk("locked_255", int'(locked), 1);

      frame(50);
      frame(50, 120);
      frame(50);
      chk("nvalid_glitch", n_valid, 11);
      chk("nerr_glitch", n_err, 1);
      frame(50);
      chk("nvalid_post_glitch", n_valid, 12);
      chk("last_post_glitch", last_s, 50);

      repeat (300) tick(1'b0);
      chk("nvalid_loss", n_valid, 13);
      chk("nerr_loss", n_err, 2);
      chk("unlocked_loss", int'(locked), 0);

      frame(100);
      chk("relock", int'(locked), 1);
      chk("nvalid_relock", n_valid, 13);
      frame(100);
      frame(100, 200);
      chk("nvalid_pre_rst", n_valid, 15);
      chk("last_pre_rst", last_s, 100);

      @(negedge clk);
      pwm_in = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      chk("midrst_sample_out", int'(sample_out), 0);
      chk("midrst_valid",      int'(sample_valid), 0);
      chk("midrst_locked",     int'(locked), 0);
      chk("midrst_err",        int'(sync_err), 0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (5) tick(1'b0);
      chk("nvalid_post_rst", n_valid, 15);

      vq.delete();
      frame(10);
      frame(21);
      repeat (8) tick(1'b0);
      chk("avg_count", vq.size(), 2);
      if (vq.size() >= 2) begin
         chk("avg_first", vq[0], 10);
`ifdef PWM_DEC_AVG_EN
         chk("avg_second", vq[1], 16);
`else
         chk("avg_second", vq[1], 21);
`endif
      end
      chk("nerr_final", n_err, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
